// File: rtl/edge_pkg.sv
// Shared Edge pipeline constants and controller state encoding.
// Used by the stream controller, Edge and the Hough accumulator.
package edge_pkg;

  localparam int BUFF = 300;
  localparam int LAT  = BUFF + 3;
  localparam int FLW  = $clog2(LAT + 1);

  localparam logic [FLW-1:0] LAT_V = FLW'(LAT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  function automatic logic cfgOk(
    input logic [15:0] w,
    input logic [15:0] h
  );
    return (w != 16'd0) && (h != 16'd0) &&
           (w <= 16'(BUFF));
  endfunction

endpackage

// File: rtl/edge_pos_counter.sv
// Column/row position within a frame, with wrap and first/last flags.
// Ports: Clk, nReset, clear, adv, wLat/hLat in; col, row, flags out.
module edge_pos_counter (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       clear,
  input  logic       adv,
  input  logic [7:0] wLat,
  input  logic [7:0] hLat,
  output logic [7:0] col,
  output logic [7:0] row,
  output logic       first,
  output logic       lineFirst,
  output logic       last
);

  logic colLast;

  assign colLast   = (col == wLat - 8'd1);
  assign first     = (col == 8'd0) && (row == 8'd0);
  assign lineFirst = (col == 8'd0);
  assign last      = colLast && (row == hLat - 8'd1);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      col <= 8'd0;
      row <= 8'd0;
    end else if (clear) begin
      col <= 8'd0;
      row <= 8'd0;
    end else if (adv) begin
      if (colLast) begin
        col <= 8'd0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/edge_stream_ctrl.sv
// Feeds one frame from a valid/ready source into Edge, then flushes.
// Ports: Start/Width/Height cfg, Src* stream in, Edge* out, status out.
module edge_stream_ctrl
  import edge_pkg::*;
(
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic [7:0] Width,
  input  logic [7:0] Height,
  input  logic [7:0] SrcPixel,
  input  logic       SrcValid,
  output logic       SrcReady,
  output logic [7:0] EdgePixel,
  output logic       EdgeFrame,
  output logic       EdgeLine,
  output logic [7:0] EdgeWidth,
  output logic       Busy,
  output logic       Done,
  output logic       CfgErr,
  output logic       Underrun
);

  state_t state;
  state_t nextState;

  logic [FLW-1:0] flush;
  logic [FLW-1:0] flushD;
  logic [7:0]     wLat;
  logic [7:0]     hLat;
  logic           aborted;
  logic           abortD;

  logic [7:0] col;
  logic [7:0] row;
  logic       first;
  logic       lineFirst;
  logic       last;

  logic       xfer;
  logic       startOk;
  logic       accept;
  logic [7:0] pixD;
  logic       frameD;
  logic       lineD;
  logic       doneD;
  logic       cfgErrD;
  logic       underrunD;

  assign xfer    = SrcValid && (state == RUN);
  assign startOk = cfgOk({8'h00, Width}, {8'h00, Height});
  assign EdgeWidth = wLat;

  edge_pos_counter uPos (
    .Clk       (Clk),
    .nReset    (nReset),
    .clear     (accept),
    .adv       (xfer),
    .wLat      (wLat),
    .hLat      (hLat),
    .col       (col),
    .row       (row),
    .first     (first),
    .lineFirst (lineFirst),
    .last      (last)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (Start && startOk) nextState = RUN;
      end
      RUN: begin
        if (xfer && last)          nextState = FLUSH;
        else if (!SrcValid && !first) nextState = FLUSH;
      end
      FLUSH: begin
        if (flush == FLW'(1)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    pixD      = 8'd0;
    frameD    = 1'b0;
    lineD     = 1'b0;
    doneD     = 1'b0;
    cfgErrD   = 1'b0;
    underrunD = Underrun;
    flushD    = flush;
    abortD    = aborted;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (startOk) begin
            accept    = 1'b1;
            underrunD = 1'b0;
            abortD    = 1'b0;
          end else begin
            cfgErrD = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          pixD   = SrcPixel;
          frameD = first;
          lineD  = lineFirst;
          if (last) flushD = LAT_V;
        end else if (!first) begin
          // Edge cannot stall, so a mid-frame gap kills the frame
          underrunD = 1'b1;
          abortD    = 1'b1;
          flushD    = LAT_V;
        end
      end
      FLUSH: begin
        flushD = flush - FLW'(1);
        if (flush == FLW'(1)) doneD = !aborted;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      flush     <= '0;
      wLat      <= 8'd0;
      hLat      <= 8'd0;
      aborted   <= 1'b0;
      EdgePixel <= 8'd0;
      EdgeFrame <= 1'b0;
      EdgeLine  <= 1'b0;
      Done      <= 1'b0;
      CfgErr    <= 1'b0;
      Underrun  <= 1'b0;
      SrcReady  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      flush     <= flushD;
      aborted   <= abortD;
      EdgePixel <= pixD;
      EdgeFrame <= frameD;
      EdgeLine  <= lineD;
      Done      <= doneD;
      CfgErr    <= cfgErrD;
      Underrun  <= underrunD;
      SrcReady  <= (nextState == RUN);
      Busy      <= (nextState != IDLE);
      if (accept) begin
        wLat <= Width;
        hLat <= Height;
      end
    end
  end

endmodule

// File: tb/tb_edge_stream_ctrl.sv
// Self-checking bench for edge_stream_ctrl.
// Table-driven cycle vectors plus directed multi-cycle sequences.
module tb_edge_stream_ctrl;
  import edge_pkg::*;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Width = 8'd0;
  logic [7:0] Height = 8'd0;
  logic [7:0] SrcPixel = 8'd0;
  logic       SrcValid = 1'b0;
  logic       SrcReady;
  logic [7:0] EdgePixel;
  logic       EdgeFrame;
  logic       EdgeLine;
  logic [7:0] EdgeWidth;
  logic       Busy;
  logic       Done;
  logic       CfgErr;
  logic       Underrun;

  int pass = 0;
  int total = 0;

  edge_stream_ctrl dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Start     (Start),
    .Width     (Width),
    .Height    (Height),
    .SrcPixel  (SrcPixel),
    .SrcValid  (SrcValid),
    .SrcReady  (SrcReady),
    .EdgePixel (EdgePixel),
    .EdgeFrame (EdgeFrame),
    .EdgeLine  (EdgeLine),
    .EdgeWidth (EdgeWidth),
    .Busy      (Busy),
    .Done      (Done),
    .CfgErr    (CfgErr),
    .Underrun  (Underrun)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       st;
    logic [7:0] w;
    logic [7:0] h;
    logic       v;
    logic [7:0] pix;
    logic [7:0] ePix;
    logic       rdy;
    logic       busy;
    logic       frm;
    logic       lin;
    logic       done;
    logic       cfg;
    logic       und;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic st, input logic [7:0] w, input logic [7:0] h,
    input logic v, input logic [7:0] pix, input logic [7:0] ePix,
    input logic rdy, input logic busy, input logic frm,
    input logic lin, input logic cfg
  );
    vec_t r;
    r.st = st; r.w = w; r.h = h; r.v = v; r.pix = pix;
    r.ePix = ePix; r.rdy = rdy; r.busy = busy; r.frm = frm;
    r.lin = lin; r.done = 1'b0; r.cfg = cfg; r.und = 1'b0;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {8'd0, SrcReady, Busy, Done, CfgErr, Underrun,
            EdgeFrame, EdgeLine, EdgePixel, EdgeWidth, 1'b0};
  endfunction

  task automatic drain(input int base, output int cnt,
                       output bit sawDone, output bit dirty);
    cnt = base;
    sawDone = 0;
    dirty = 0;
    for (int k = 0; k < 4000 && Busy; k++) begin
      if (Done) sawDone = 1;
      if (EdgePixel != 8'd0 || EdgeFrame || EdgeLine) dirty = 1;
      tick();
      if (Busy) cnt++;
    end
  endtask

  initial begin
    int cnt;
    bit sawDone;
    bit dirty;
    vec_t e;
    logic [17:0] act;
    logic [17:0] exp;

    #2;
    check("reset_outputs", outs(), 32'd0);
    tick();
    nReset = 1'b1;
    tick();
    check("idle_outputs", outs(), 32'd0);

    tbl.push_back(mk(1, 8'd0, 8'd3, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'd4, 8'd0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'd4, 8'd3, 1, 8'h55, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(i == 5, 8'd1, 8'd1, 1, 8'(8'h10 + i),
                       8'(8'h10 + i), i < 11, 1, i == 0,
                       (i % 4) == 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      Start = e.st;
      Width = e.w;
      Height = e.h;
      SrcValid = e.v;
      SrcPixel = e.pix;
      tick();
      act = {SrcReady, Busy, EdgeFrame, EdgeLine, Done,
             CfgErr, Underrun, EdgePixel, 3'b0};
      exp = {e.rdy, e.busy, e.frm, e.lin, e.done,
             e.cfg, e.und, e.ePix, 3'b0};
      if (act !== exp)
        $display("FAIL vec%0d: got %0h expected %0h", i, act, exp);
      total++;
      if (act === exp) pass++;
    end
    Start = 1'b0;
    check("edge_width_latched", {24'd0, EdgeWidth}, 32'd4);

    tick();
    drain(14, cnt, sawDone, dirty);
    check("frame_busy_cycles", cnt, 32'(12 + LAT));
    check("frame_flush_zero", {31'd0, dirty}, 32'd0);
    check("frame_no_early_done", {31'd0, sawDone}, 32'd0);
    check("frame_done_pulse", {31'd0, Done}, 32'd1);
    tick();
    check("frame_done_single", {31'd0, Done}, 32'd0);

    Start = 1'b1; Width = 8'd4; Height = 8'd3; SrcValid = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SrcPixel = 8'(8'h20 + i);
      tick();
    end
    check("abort_last_pixel", {24'd0, EdgePixel}, 32'h25);
    SrcValid = 1'b0;
    tick();
    check("abort_underrun", {30'd0, Underrun, SrcReady}, 32'd2);
    drain(1, cnt, sawDone, dirty);
    check("abort_flush_len", cnt, 32'(LAT));
    check("abort_flush_zero", {31'd0, dirty}, 32'd0);
    tick();
    check("abort_no_done", {30'd0, sawDone, Done}, 32'd0);
    check("abort_underrun_sticky", {31'd0, Underrun}, 32'd1);

    Start = 1'b1; Width = 8'd1; Height = 8'd1;
    tick();
    Start = 1'b0;
    check("one_start_clears", {30'd0, Underrun, Busy}, 32'd1);
    SrcValid = 1'b1; SrcPixel = 8'hAB;
    tick();
    SrcValid = 1'b0;
    check("one_pixel", {22'd0, EdgePixel, EdgeFrame, EdgeLine},
          {22'd0, 8'hAB, 2'b11});
    tick();
    drain(3, cnt, sawDone, dirty);
    check("one_busy_cycles", cnt, 32'(1 + LAT));
    check("one_flush_zero", {31'd0, dirty}, 32'd0);
    check("one_done", {31'd0, Done}, 32'd1);
    tick();

    Start = 1'b1; Width = 8'd4; Height = 8'd3; SrcValid = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SrcPixel = 8'(8'h40 + i);
      tick();
    end
    nReset = 1'b0;
    #1;
    check("rst_async_clear", outs(), 32'd0);
    tick();
    check("rst_held", outs(), 32'd0);
    nReset = 1'b1;
    SrcValid = 1'b0;
    tick();
    check("rst_idle", outs(), 32'd0);

    Start = 1'b1; Width = 8'd2; Height = 8'd2;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      SrcValid = 1'b1;
      SrcPixel = 8'(8'h60 + i);
      tick();
      check($sformatf("post_rst_px%0d", i),
            {22'd0, EdgePixel, EdgeFrame, EdgeLine},
            {22'd0, 8'(8'h60 + i), i == 0, (i % 2) == 0});
    end
    SrcValid = 1'b0;
    tick();
    drain(6, cnt, sawDone, dirty);
    check("post_rst_busy", cnt, 32'(4 + LAT));
    check("post_rst_done", {30'd0, Done, Underrun}, 32'd2);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
